// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback/commit stage.
package wb_pkg;

  // Commit FSM states
  typedef enum logic {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  // Data source select values carried by ADR_MUX
  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Stack pointer operation applied at commit
  typedef enum logic [1:0] {
    SP_HOLD  = 2'd0,
    SP_WRITE = 2'd1,
    SP_INC   = 2'd2,
    SP_DEC   = 2'd3
  } sp_op_t;

  // Reduce the three SP control bits to one operation; a write wins,
  // and an increment together with a decrement cancels out.
  function automatic sp_op_t sp_op_decode(input logic w, input logic i, input logic d);
    sp_op_t op;
    if (w) begin
      op = SP_WRITE;
    end else if (i && !d) begin
      op = SP_INC;
    end else if (d && !i) begin
      op = SP_DEC;
    end else begin
      op = SP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/sp_register.sv
// Stack pointer register: load, wrapping increment/decrement, or hold.
module sp_register
  import wb_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] SP_RESET = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sp
);

  logic [WIDTH-1:0] sp_r;

  // Apply the requested SP operation; arithmetic wraps modulo 2^WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= SP_RESET;
    end else begin
      case (op)
        SP_WRITE: sp_r <= data;
        SP_INC:   sp_r <= sp_r + WIDTH'(1);
        SP_DEC:   sp_r <= sp_r - WIDTH'(1);
        SP_HOLD:  sp_r <= sp_r;
        default:  sp_r <= sp_r;
      endcase
    end
  end

  assign sp = sp_r;

endmodule

// File: rtl/writeback_commit_unit.sv
// Writeback/commit stage: commits register-file writes, PC loads and SP
// updates, parking ops that wait on memory data in a hold register.
module writeback_commit_unit
  import wb_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] SP_RESET    = {WIDTH{1'b1}},
  parameter int               MEM_TIMEOUT = 15,
  parameter int               CNT_WIDTH   = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [2:0]           writeAd_IN,
  input  logic                 ADR_MUX_IN,
  input  logic                 write_IN,
  input  logic                 PC_load_IN,
  input  logic                 SPR_w_IN,
  input  logic                 SPR_i_IN,
  input  logic                 SPR_d_IN,
  input  logic [WIDTH-1:0]     ALU_DATA_IN,
  input  logic [WIDTH-1:0]     MEM_DATA_IN,
  input  logic                 MEM_READY_IN,
  output logic                 STALL_OUT,
  output logic                 RF_WE_OUT,
  output logic [2:0]           RF_ADDR_OUT,
  output logic [WIDTH-1:0]     RF_DATA_OUT,
  output logic                 PC_LOAD_OUT,
  output logic [WIDTH-1:0]     PC_TARGET_OUT,
  output logic [WIDTH-1:0]     SP_OUT,
  output logic [CNT_WIDTH-1:0] RETIRED_OUT,
  output logic                 ERR_OUT
);

  localparam int            TW           = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(MEM_TIMEOUT);

  wb_state_t            state_r;
  logic [2:0]           hold_addr_r;
  logic                 hold_write_r;
  logic                 hold_pc_r;
  sp_op_t               hold_sp_op_r;
  logic [TW-1:0]        to_cnt_r;
  logic                 rf_we_r;
  logic [2:0]           rf_addr_r;
  logic [WIDTH-1:0]     rf_data_r;
  logic                 pc_load_r;
  logic [WIDTH-1:0]     pc_target_r;
  logic [CNT_WIDTH-1:0] retired_r;
  logic                 err_r;

  logic                 active_s;
  logic                 needs_mem_s;
  logic                 stall_s;
  logic                 commit_s;
  logic                 enter_wait_s;
  logic [2:0]           commit_addr_s;
  logic                 commit_write_s;
  logic                 commit_pc_s;
  sp_op_t               commit_sp_op_s;
  logic [WIDTH-1:0]     commit_data_s;
  logic [1:0]           sp_op_s;
  logic [TW-1:0]        to_next_s;

  // Decide whether this cycle commits, parks an op, or idles, and pick the op source
  always_comb begin
    active_s       = write_IN | PC_load_IN | SPR_w_IN | SPR_i_IN | SPR_d_IN;
    needs_mem_s    = active_s & (ADR_MUX_IN == SRC_MEM);
    stall_s        = 1'b0;
    commit_s       = 1'b0;
    enter_wait_s   = 1'b0;
    commit_addr_s  = writeAd_IN;
    commit_write_s = write_IN;
    commit_pc_s    = PC_load_IN;
    commit_sp_op_s = sp_op_decode(SPR_w_IN, SPR_i_IN, SPR_d_IN);
    commit_data_s  = (ADR_MUX_IN == SRC_MEM) ? MEM_DATA_IN : ALU_DATA_IN;
    to_next_s      = to_cnt_r + TW'(1);
    case (state_r)
      RUN: begin
        if (active_s && (!needs_mem_s || MEM_READY_IN)) begin
          commit_s = 1'b1;
        end else if (needs_mem_s) begin
          stall_s      = 1'b1;
          enter_wait_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      WAIT_MEM: begin
        stall_s        = 1'b1;
        commit_addr_s  = hold_addr_r;
        commit_write_s = hold_write_r;
        commit_pc_s    = hold_pc_r;
        commit_sp_op_s = hold_sp_op_r;
        commit_data_s  = MEM_DATA_IN;
        if (MEM_READY_IN) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      default: begin
        stall_s  = 1'b0;
        commit_s = 1'b0;
      end
    endcase
    if (commit_s) begin
      sp_op_s = commit_sp_op_s;
    end else begin
      sp_op_s = SP_HOLD;
    end
  end

  // FSM, hold register, timeout counter and registered commit outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r      <= RUN;
      hold_addr_r  <= 3'd0;
      hold_write_r <= 1'b0;
      hold_pc_r    <= 1'b0;
      hold_sp_op_r <= SP_HOLD;
      to_cnt_r     <= '0;
      rf_we_r      <= 1'b0;
      rf_addr_r    <= 3'd0;
      rf_data_r    <= '0;
      pc_load_r    <= 1'b0;
      pc_target_r  <= '0;
      retired_r    <= '0;
      err_r        <= 1'b0;
    end else begin
      rf_we_r   <= commit_s & commit_write_s;
      pc_load_r <= commit_s & commit_pc_s;
      if (commit_s) begin
        rf_addr_r   <= commit_addr_s;
        rf_data_r   <= commit_data_s;
        pc_target_r <= commit_data_s;
        retired_r   <= retired_r + CNT_WIDTH'(1);
      end
      case (state_r)
        RUN: begin
          if (enter_wait_s) begin
            state_r      <= WAIT_MEM;
            hold_addr_r  <= commit_addr_s;
            hold_write_r <= commit_write_s;
            hold_pc_r    <= commit_pc_s;
            hold_sp_op_r <= commit_sp_op_s;
            to_cnt_r     <= '0;
          end
        end
        WAIT_MEM: begin
          if (MEM_READY_IN) begin
            state_r  <= RUN;
            to_cnt_r <= '0;
          end else if (to_next_s == TIMEOUT_LAST) begin
            // Memory never answered: drop the held op and flag it
            state_r  <= RUN;
            to_cnt_r <= '0;
            err_r    <= 1'b1;
          end else begin
            to_cnt_r <= to_next_s;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  sp_register #(
    .WIDTH    (WIDTH),
    .SP_RESET (SP_RESET)
  ) u_sp (
    .clk   (CLK),
    .rst_n (RST_N),
    .op    (sp_op_s),
    .data  (commit_data_s),
    .sp    (SP_OUT)
  );

  assign STALL_OUT     = stall_s;
  assign RF_WE_OUT     = rf_we_r;
  assign RF_ADDR_OUT   = rf_addr_r;
  assign RF_DATA_OUT   = rf_data_r;
  assign PC_LOAD_OUT   = pc_load_r;
  assign PC_TARGET_OUT = pc_target_r;
  assign RETIRED_OUT   = retired_r;
  assign ERR_OUT       = err_r;

endmodule

// File: tb/tb_writeback_commit_unit.sv
// Self-checking bench for writeback_commit_unit: directed scenarios followed
// by random traffic, all compared against a cycle-level behavioural model.
module tb_writeback_commit_unit;

  localparam int W  = 16;
  localparam int TO = 15;
  localparam int CW = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [2:0]    writeAd_IN;
  logic          ADR_MUX_IN, write_IN, PC_load_IN, SPR_w_IN, SPR_i_IN, SPR_d_IN;
  logic [W-1:0]  ALU_DATA_IN, MEM_DATA_IN;
  logic          MEM_READY_IN;
  logic          STALL_OUT, RF_WE_OUT, PC_LOAD_OUT, ERR_OUT;
  logic [2:0]    RF_ADDR_OUT;
  logic [W-1:0]  RF_DATA_OUT, PC_TARGET_OUT, SP_OUT;
  logic [CW-1:0] RETIRED_OUT;

  writeback_commit_unit #(
    .WIDTH(W), .SP_RESET(16'hFFFF), .MEM_TIMEOUT(TO), .CNT_WIDTH(CW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .writeAd_IN(writeAd_IN), .ADR_MUX_IN(ADR_MUX_IN),
    .write_IN(write_IN), .PC_load_IN(PC_load_IN), .SPR_w_IN(SPR_w_IN),
    .SPR_i_IN(SPR_i_IN), .SPR_d_IN(SPR_d_IN), .ALU_DATA_IN(ALU_DATA_IN),
    .MEM_DATA_IN(MEM_DATA_IN), .MEM_READY_IN(MEM_READY_IN), .STALL_OUT(STALL_OUT),
    .RF_WE_OUT(RF_WE_OUT), .RF_ADDR_OUT(RF_ADDR_OUT), .RF_DATA_OUT(RF_DATA_OUT),
    .PC_LOAD_OUT(PC_LOAD_OUT), .PC_TARGET_OUT(PC_TARGET_OUT), .SP_OUT(SP_OUT),
    .RETIRED_OUT(RETIRED_OUT), .ERR_OUT(ERR_OUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a pending memory op plus how long it has waited
  bit           m_pending;
  int           m_age;
  logic [2:0]   p_addr;
  bit           p_we, p_pc, p_w, p_i, p_d;
  logic [W-1:0] e_sp, e_data, e_target;
  logic [2:0]   e_addr;
  bit           e_we, e_pc, e_err;
  logic [CW-1:0] e_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] a, input logic adr, input logic we, input logic pc,
                        input logic w, input logic i, input logic d,
                        input logic [W-1:0] alu, input logic [W-1:0] mem, input logic rdy);
    writeAd_IN = a; ADR_MUX_IN = adr; write_IN = we; PC_load_IN = pc;
    SPR_w_IN = w; SPR_i_IN = i; SPR_d_IN = d;
    ALU_DATA_IN = alu; MEM_DATA_IN = mem; MEM_READY_IN = rdy;
  endtask

  task automatic model_commit(input logic [2:0] a, input bit we, input bit pc, input bit w,
                              input bit i, input bit d, input logic [W-1:0] data);
    e_we = we; e_pc = pc; e_addr = a; e_data = data; e_target = data;
    e_ret = e_ret + 16'd1;
    if (w) e_sp = data;
    else if (i && !d) e_sp = e_sp + 16'd1;
    else if (d && !i) e_sp = e_sp - 16'd1;
  endtask

  task automatic model_reset();
    m_pending = 0; m_age = 0;
    e_sp = 16'hFFFF; e_data = '0; e_target = '0; e_addr = '0;
    e_we = 0; e_pc = 0; e_err = 0; e_ret = '0;
  endtask

  task automatic check_outputs();
    chk("rf_we", RF_WE_OUT, e_we);
    chk("rf_addr", RF_ADDR_OUT, e_addr);
    chk("rf_data", RF_DATA_OUT, e_data);
    chk("pc_load", PC_LOAD_OUT, e_pc);
    chk("pc_target", PC_TARGET_OUT, e_target);
    chk("sp", SP_OUT, e_sp);
    chk("retired", RETIRED_OUT, e_ret);
    chk("err", ERR_OUT, e_err);
  endtask

  // One clock: check stall before the edge, advance the model, check outputs after
  task automatic step();
    bit active;
    bit stall_e;
    #3;
    active  = write_IN | PC_load_IN | SPR_w_IN | SPR_i_IN | SPR_d_IN;
    stall_e = m_pending || (active && ADR_MUX_IN && !MEM_READY_IN);
    chk("stall", STALL_OUT, stall_e);
    e_we = 0; e_pc = 0;
    if (m_pending) begin
      if (MEM_READY_IN) begin
        model_commit(p_addr, p_we, p_pc, p_w, p_i, p_d, MEM_DATA_IN);
        m_pending = 0;
      end else begin
        m_age++;
        if (m_age == TO) begin
          m_pending = 0;
          e_err = 1;
        end
      end
    end else if (active) begin
      if (!ADR_MUX_IN || MEM_READY_IN) begin
        model_commit(writeAd_IN, write_IN, PC_load_IN, SPR_w_IN, SPR_i_IN, SPR_d_IN,
                     ADR_MUX_IN ? MEM_DATA_IN : ALU_DATA_IN);
      end else begin
        m_pending = 1; m_age = 0;
        p_addr = writeAd_IN; p_we = write_IN; p_pc = PC_load_IN;
        p_w = SPR_w_IN; p_i = SPR_i_IN; p_d = SPR_d_IN;
      end
    end
    @(posedge CLK);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse taken away from the clock edge
  task automatic do_reset();
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("reset_stall", STALL_OUT, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  int rdy_pct;

  initial begin
    RST_N = 1'b0;
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Plain ALU write
    set_in(3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0, 1'b0);
    step();
    chk("alu_we", RF_WE_OUT, 1'b1);
    chk("alu_data", RF_DATA_OUT, 16'h1234);
    chk("alu_addr", RF_ADDR_OUT, 3'd5);
    chk("alu_retired", RETIRED_OUT, 16'd1);

    // Memory op: ready low for three cycles, then data arrives
    set_in(3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5555, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mem_wait_no_we", RF_WE_OUT, 1'b0);
    end
    MEM_DATA_IN = 16'hABCD; MEM_READY_IN = 1'b1;
    step();
    chk("mem_we", RF_WE_OUT, 1'b1);
    chk("mem_data", RF_DATA_OUT, 16'hABCD);
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    chk("mem_no_dup", RF_WE_OUT, 1'b0);
    chk("mem_retired", RETIRED_OUT, 16'd2);

    // Stack pointer wrap and priority sequence
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    step(); chk("sp_inc_wrap", SP_OUT, 16'h0000);
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    step(); chk("sp_dec_wrap", SP_OUT, 16'hFFFF);
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 1'b0);
    step(); chk("sp_inc_dec", SP_OUT, 16'hFFFF);
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0100, 16'h0, 1'b0);
    step(); chk("sp_write_prio", SP_OUT, 16'h0100);

    // PC load and register write in the same op
    set_in(3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0042, 16'h0, 1'b0);
    step();
    chk("pc_we_pair", {PC_LOAD_OUT, RF_WE_OUT}, 2'b11);
    chk("pc_target_42", PC_TARGET_OUT, 16'h0042);

    // Memory timeout: op dropped, error set, stall released
    set_in(3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h9999, 1'b0);
    for (int k = 0; k < TO + 1; k++) begin
      step();
      chk("timeout_no_we", RF_WE_OUT, 1'b0);
    end
    chk("timeout_err", ERR_OUT, 1'b1);
    set_in(3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777, 16'h0, 1'b0);
    step();
    chk("after_timeout_we", RF_WE_OUT, 1'b1);
    chk("after_timeout_data", RF_DATA_OUT, 16'h7777);
    chk("err_sticky", ERR_OUT, 1'b1);

    // Reset while waiting on memory discards the held op
    set_in(3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    step();
    do_reset();
    set_in(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h3333, 1'b1);
    step();
    chk("rst_wait_no_we", RF_WE_OUT, 1'b0);
    chk("rst_wait_sp", SP_OUT, 16'hFFFF);
    chk("rst_wait_retired", RETIRED_OUT, 16'd0);

    // Random traffic alternating responsive and sluggish memory
    for (int n = 0; n < 600; n++) begin
      rdy_pct = ((n / 100) % 2 == 0) ? 70 : 4;
      set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 2) == 0),
             16'($urandom), 16'($urandom), 1'($urandom_range(0, 99) < rdy_pct));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
